// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: instruction input side and immediate result output side.
// slave = the stage itself, master = whoever drives instructions and consumes results.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_unknown;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_unknown
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_unknown
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate generator stage: decodes the RISC-V format, sign-extends the immediate, 2-entry skid buffer.
// Optional CSR-immediate (type Z) decode is enabled by defining IMM_GEN_ZICSR_EN.
//
// state   | meaning
// EMPTY   | no result held, out_valid = 0
// ONE     | output register holds the oldest result
// FULL    | output register plus skid register both hold results, in_ready = 0
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_stage_if.slave   bus,
  output logic [CNT_W-1:0] unknown_cnt
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] T_Z    = 3'd6;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [6:0]      w_opcode;
  logic [2:0]      w_dec_type;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_unknown;

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_load_out_dec;
  logic            w_load_out_skid;
  logic            w_load_skid;

  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_type;
  logic            r_out_unknown;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_type;
  logic            r_skid_unknown;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = bus.in_instr[6:0];

  always_comb begin
    w_dec_type = T_NONE;
    case (w_opcode)
      7'b0000011, 7'b0010011, 7'b1100111: w_dec_type = T_I;
      7'b0011011: if (XLEN == 64) w_dec_type = T_I;
      7'b0100011: w_dec_type = T_S;
      7'b1100011: w_dec_type = T_B;
      7'b0110111, 7'b0010111: w_dec_type = T_U;
      7'b1101111: w_dec_type = T_J;
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: if (bus.in_instr[14]) w_dec_type = T_Z;
`endif
      default: w_dec_type = T_NONE;
    endcase
  end

  // Sized casts of signed operands sign-extend to XLEN regardless of the chosen width.
  always_comb begin
    w_dec_imm = '0;
    case (w_dec_type)
      T_I: w_dec_imm = XLEN'($signed(bus.in_instr[31:20]));
      T_S: w_dec_imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
      T_B: w_dec_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                      bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
      T_U: w_dec_imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      T_J: w_dec_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                      bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
`ifdef IMM_GEN_ZICSR_EN
      T_Z: w_dec_imm = XLEN'(bus.in_instr[19:15]);
`endif
      default: w_dec_imm = '0;
    endcase
  end

  assign w_dec_unknown = (w_dec_type == T_NONE);

  // in_ready is gated by rst so nothing can be accepted while reset is held.
  assign bus.in_ready  = !rst && (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign w_in_xfer     = bus.in_valid && bus.in_ready;
  assign w_out_xfer    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    w_load_out_dec  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_next         = S_ONE;
          w_load_out_dec = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_next         = S_ONE;
          w_load_out_dec = 1'b1;
        end else if (w_in_xfer) begin
          w_next      = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_xfer) begin
          w_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_xfer) begin
          w_next          = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_imm      <= '0;
      r_out_type     <= T_NONE;
      r_out_unknown  <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_type    <= T_NONE;
      r_skid_unknown <= 1'b0;
    end else begin
      if (w_load_out_dec) begin
        r_out_imm     <= w_dec_imm;
        r_out_type    <= w_dec_type;
        r_out_unknown <= w_dec_unknown;
      end else if (w_load_out_skid) begin
        r_out_imm     <= r_skid_imm;
        r_out_type    <= r_skid_type;
        r_out_unknown <= r_skid_unknown;
      end
      if (w_load_skid) begin
        r_skid_imm     <= w_dec_imm;
        r_skid_type    <= w_dec_type;
        r_skid_unknown <= w_dec_unknown;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_in_xfer && w_dec_unknown && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_imm     = r_out_imm;
  assign bus.out_type    = r_out_type;
  assign bus.out_unknown = r_out_unknown;
  assign unknown_cnt     = r_cnt;

endmodule
